// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and read-mode constants for the parametrised FIFO.
package fifo_pkg;

    localparam bit FWFT_OFF = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the counter can hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return n >= 2 && (n & (n - 1)) == 0;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with threshold flags, error pulses and registered/FWFT read modes.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = FWFT_OFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ip,
    input  logic                     wr,
    input  logic                     rd,
    output logic [WIDTH-1:0]         op,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow,
    output logic [cnt_w(DEPTH)-1:0]  cnt
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (!is_pow2(DEPTH) || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $error("sync_fifo_param: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_q, op_d, rdata;
    logic             overflow_q, underflow_q, wr_ok, rd_ok;

    assign empty        = cnt_q == '0;
    assign full         = cnt_q == CW'(DEPTH);
    assign almost_empty = cnt_q <= CW'(AE_LEVEL);
    assign almost_full  = cnt_q >= CW'(AF_LEVEL);

    // Acceptance uses pre-edge flags, so a full FIFO never passes a write through the slot freed by a read.
    always_comb begin
        wr_ok    = wr && !full;
        rd_ok    = rd && !empty;
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = (wr_ok && !rd_ok) ? cnt_q + 1'b1 :
                   (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
        op_d     = rd_ok ? rdata : op_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            overflow_q  <= wr && full;
            underflow_q <= rd && empty;
        end
    end

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we_i   (wr_ok),
        .waddr_i(wr_ptr_q),
        .wdata_i(ip),
        .raddr_i(rd_ptr_q),
        .rdata_o(rdata)
    );

    // FWFT shows the head word straight from registered state; zero while nothing is stored.
    assign op        = FWFT ? (empty ? '0 : rdata) : op_q;
    assign cnt       = cnt_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
